crc_engine: RTL and testbench

Parametrised streaming CRC engine and the successor to the team's bit-serial CRC calculator. It consumes DATA_WIDTH bits per clock over a valid/ready stream with start/end-of-frame markers. It computes any CRC up to 32 bits in the standard parametrised model (poly, init, reflect-in, reflect-out, xor-out) and presents the finished CRC and the frame beat count on a valid/ready result port. It sits between a byte/word stream source and a frame checker or packetiser.

---
 rtl/crc_engine.sv | 150 +++++++++++++++
 tb/tb_crc_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// Streaming parametrised CRC engine: folds one DATA_WIDTH beat per cycle into a
// CRC_WIDTH register and presents the finished CRC plus beat count on a result port.
module crc_engine #(
  parameter int CRC_WIDTH  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRC_WIDTH-1:0]  crc_poly,
  input  logic [CRC_WIDTH-1:0]  crc_init,
  input  logic [CRC_WIDTH-1:0]  crc_xorout,
  input  logic                  reflect_in,
  input  logic                  reflect_out,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic                  frame_err
);

  // Handshakes: a beat moves on s_valid && s_ready, a result on m_valid && m_ready;
  // s_ready is decoded from registered state only, so it never depends on s_valid or m_ready.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                state;
  logic [CRC_WIDTH-1:0]  crc_q;
  logic [CRC_WIDTH-1:0]  poly_q;
  logic [CRC_WIDTH-1:0]  xorout_q;
  logic                  rin_q;
  logic                  rout_q;
  logic [LEN_WIDTH-1:0]  len_q;

  logic                  accept;
  logic [CRC_WIDTH-1:0]  eff_poly;
  logic [CRC_WIDTH-1:0]  eff_xorout;
  logic                  eff_rin;
  logic                  eff_rout;
  logic [CRC_WIDTH-1:0]  base_crc;
  logic [CRC_WIDTH-1:0]  next_crc;
  logic [CRC_WIDTH-1:0]  final_crc;
  logic [LEN_WIDTH-1:0]  next_len;

  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0]  c,
    input logic [DATA_WIDTH-1:0] d,
    input logic [CRC_WIDTH-1:0]  poly,
    input logic                  refl
  );
    logic [CRC_WIDTH-1:0] r;
    logic                 b;
    logic                 fb;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      b  = refl ? d[DATA_WIDTH-1-i] : d[i];
      fb = r[CRC_WIDTH-1] ^ b;
      r  = {r[CRC_WIDTH-2:0], 1'b0};
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] bitrev(input logic [CRC_WIDTH-1:0] v);
    logic [CRC_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_WIDTH; i++) r[CRC_WIDTH-1-i] = v[i];
    return r;
  endfunction

  assign s_ready = (state != RESULT);
  assign accept  = s_valid && s_ready;

  // A sof beat runs on the live config; every other beat uses the copy latched at sof.
  always_comb begin
    eff_poly   = s_sof ? crc_poly    : poly_q;
    eff_xorout = s_sof ? crc_xorout  : xorout_q;
    eff_rin    = s_sof ? reflect_in  : rin_q;
    eff_rout   = s_sof ? reflect_out : rout_q;
    base_crc   = s_sof ? crc_init    : crc_q;
    next_crc   = crc_step(base_crc, s_data, eff_poly, eff_rin);
    final_crc  = (eff_rout ? bitrev(next_crc) : next_crc) ^ eff_xorout;
    if (s_sof)       next_len = LEN_WIDTH'(1);
    else if (&len_q) next_len = len_q;
    else             next_len = len_q + LEN_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_q     <= '0;
      poly_q    <= '0;
      xorout_q  <= '0;
      rin_q     <= 1'b0;
      rout_q    <= 1'b0;
      len_q     <= '0;
      m_valid   <= 1'b0;
      m_crc     <= '0;
      m_len     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE, ACTIVE: begin
          if (accept) begin
            if (s_sof || state == ACTIVE) begin
              crc_q <= next_crc;
              len_q <= next_len;
              if (s_sof) begin
                poly_q   <= crc_poly;
                xorout_q <= crc_xorout;
                rin_q    <= reflect_in;
                rout_q   <= reflect_out;
              end
              // sof while a frame is open abandons that frame
              frame_err <= s_sof && (state == ACTIVE);
              if (s_eof) begin
                m_valid <= 1'b1;
                m_crc   <= final_crc;
                m_len   <= next_len;
                state   <= RESULT;
              end else begin
                state <= ACTIVE;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: three instances (8/16/32-bit CRC) share one beat stream and are
// checked every cycle against a frame-level reference model plus known check values.
module tb_crc_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_valid = 1'b0;
  logic        s_sof   = 1'b0;
  logic        s_eof   = 1'b0;
  logic [7:0]  s_data  = 8'd0;
  logic        m_ready = 1'b0;

  logic [31:0] poly [3];
  logic [31:0] init [3];
  logic [31:0] xo   [3];
  logic        rin  [3];
  logic        rout [3];

  logic [7:0]  m_crc8;
  logic [15:0] m_crc16;
  logic [31:0] m_crc32;
  logic        act_rdy [3];
  logic        act_vld [3];
  logic        act_err [3];
  logic [3:0]  act_len [3];
  logic [31:0] act_crc [3];

  assign act_crc[0] = {24'd0, m_crc8};
  assign act_crc[1] = {16'd0, m_crc16};
  assign act_crc[2] = m_crc32;

  crc_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .crc_poly(poly[0][7:0]), .crc_init(init[0][7:0]), .crc_xorout(xo[0][7:0]),
    .reflect_in(rin[0]), .reflect_out(rout[0]),
    .s_valid(s_valid), .s_ready(act_rdy[0]), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(act_vld[0]), .m_ready(m_ready), .m_crc(m_crc8), .m_len(act_len[0]),
    .frame_err(act_err[0])
  );

  crc_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .crc_poly(poly[1][15:0]), .crc_init(init[1][15:0]), .crc_xorout(xo[1][15:0]),
    .reflect_in(rin[1]), .reflect_out(rout[1]),
    .s_valid(s_valid), .s_ready(act_rdy[1]), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(act_vld[1]), .m_ready(m_ready), .m_crc(m_crc16), .m_len(act_len[1]),
    .frame_err(act_err[1])
  );

  crc_engine #(.CRC_WIDTH(32), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .crc_poly(poly[2]), .crc_init(init[2]), .crc_xorout(xo[2]),
    .reflect_in(rin[2]), .reflect_out(rout[2]),
    .s_valid(s_valid), .s_ready(act_rdy[2]), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(act_vld[2]), .m_ready(m_ready), .m_crc(m_crc32), .m_len(act_len[2]),
    .frame_err(act_err[2])
  );

  int n_cmp = 0;
  int n_err = 0;
  int gap_max = 0;
  bit m_hold = 1'b0;
  bit m_force = 1'b0;
  logic [7:0] msg [64];

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  frame_q [$];
  bit          busy     = 1'b0;
  bit          in_frame = 1'b0;
  bit          exp_err  = 1'b0;
  logic [31:0] exp_crc [3];
  logic [3:0]  exp_len  = 4'd0;
  logic [31:0] cpoly [3];
  logic [31:0] cinit [3];
  logic [31:0] cxo   [3];
  bit          crin  [3];
  bit          crout [3];

  function automatic int width_of(input int j);
    return (j == 0) ? 8 : (j == 1) ? 16 : 32;
  endfunction

  // Byte-at-a-time CRC over the whole collected frame.
  function automatic logic [31:0] ref_crc(input int w, input logic [31:0] p, input logic [31:0] iv,
                                          input logic [31:0] xv, input bit ri, input bit ro);
    logic [63:0] mask;
    logic [63:0] r;
    logic [63:0] t;
    logic [7:0]  b;
    logic [7:0]  rb;
    mask = (64'd1 << w) - 64'd1;
    r = {32'd0, iv} & mask;
    foreach (frame_q[k]) begin
      b = frame_q[k];
      if (ri) begin
        for (int i = 0; i < 8; i++) rb[7-i] = b[i];
        b = rb;
      end
      r = r ^ ({56'd0, b} << (w - 8));
      for (int s = 0; s < 8; s++) r = (r[w-1] ? ((r << 1) ^ {32'd0, p}) : (r << 1)) & mask;
    end
    if (ro) begin
      t = 64'd0;
      for (int i = 0; i < w; i++) t[w-1-i] = r[i];
      r = t;
    end
    r = (r ^ {32'd0, xv}) & mask;
    return r[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
      in_frame = 1'b0;
      exp_err = 1'b0;
      frame_q.delete();
    end else begin
      exp_err = 1'b0;
      if (busy) begin
        if (m_ready) busy = 1'b0;
      end else if (s_valid) begin
        if (s_sof) begin
          exp_err = in_frame;
          frame_q.delete();
          frame_q.push_back(s_data);
          for (int j = 0; j < 3; j++) begin
            cpoly[j] = poly[j]; cinit[j] = init[j]; cxo[j] = xo[j];
            crin[j] = rin[j]; crout[j] = rout[j];
          end
          in_frame = 1'b1;
        end else if (in_frame) begin
          frame_q.push_back(s_data);
        end else begin
          exp_err = 1'b1;
        end
        if (in_frame && s_eof) begin
          for (int j = 0; j < 3; j++)
            exp_crc[j] = ref_crc(width_of(j), cpoly[j], cinit[j], cxo[j], crin[j], crout[j]);
          exp_len = (frame_q.size() > 15) ? 4'd15 : 4'(frame_q.size());
          busy = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("s_ready[%0d]", j), {31'd0, act_rdy[j]}, {31'd0, !busy});
        check($sformatf("m_valid[%0d]", j), {31'd0, act_vld[j]}, {31'd0, busy});
        check($sformatf("frame_err[%0d]", j), {31'd0, act_err[j]}, {31'd0, exp_err});
        if (busy) begin
          check($sformatf("m_crc[%0d]", j), act_crc[j], exp_crc[j]);
          check($sformatf("m_len[%0d]", j), {28'd0, act_len[j]}, {28'd0, exp_len});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_ready = m_hold ? 1'b0 : (m_force ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic send_beat(input logic [7:0] d, input bit sof, input bit eof, output int edges);
    int n;
    bit rdy;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = act_rdy[0];
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_data = 8'($urandom);
    edges = n;
    if (!rdy) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: beat not accepted within %0d edges", n);
    end
  endtask

  task automatic set_std();
    poly[0] = 32'h07;       init[0] = 32'h0;        xo[0] = 32'h0;        rin[0] = 1'b0; rout[0] = 1'b0;
    poly[1] = 32'h1021;     init[1] = 32'hFFFF;     xo[1] = 32'h0;        rin[1] = 1'b0; rout[1] = 1'b0;
    poly[2] = 32'h04C11DB7; init[2] = 32'hFFFFFFFF; xo[2] = 32'hFFFFFFFF; rin[2] = 1'b1; rout[2] = 1'b1;
  endtask

  task automatic set_rand_cfg();
    for (int j = 0; j < 3; j++) begin
      poly[j] = (j == 2) ? 32'h04C11DB7 : $urandom;
      init[j] = $urandom; xo[j] = $urandom;
      rin[j] = 1'($urandom_range(0, 1)); rout[j] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic scramble_cfg();
    for (int j = 0; j < 3; j++) begin
      poly[j] = $urandom; init[j] = $urandom; xo[j] = $urandom;
      rin[j] = ~rin[j]; rout[j] = ~rout[j];
    end
  endtask

  task automatic load_123();
    for (int k = 0; k < 9; k++) msg[k] = 8'h31 + 8'(k);
  endtask

  task automatic send_frame(input int n, input bit scramble);
    int e;
    for (int k = 0; k < n; k++) begin
      send_beat(msg[k], k == 0, k == n - 1, e);
      if (k == 0 && scramble) scramble_cfg();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (act_vld[0] && n < 200) begin @(posedge clk); #1; n++; end
    if (act_vld[0]) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: result never consumed");
    end
  endtask

  task automatic check_std_lits(input string tag);
    check({tag, "_crc8"},  act_crc[0], 32'hF4);
    check({tag, "_crc16"}, act_crc[1], 32'h29B1);
    check({tag, "_crc32"}, act_crc[2], 32'hCBF43926);
    check({tag, "_len"},   {28'd0, act_len[0]}, 32'd9);
    check({tag, "_valid"}, {31'd0, act_vld[0]}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int e;
    set_std();
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_m_valid[%0d]", j), {31'd0, act_vld[j]}, 32'd0);
      check($sformatf("rst_m_crc[%0d]", j), act_crc[j], 32'd0);
      check($sformatf("rst_m_len[%0d]", j), {28'd0, act_len[j]}, 32'd0);
      check($sformatf("rst_frame_err[%0d]", j), {31'd0, act_err[j]}, 32'd0);
    end
    rst_n = 1'b1;

    // standard check values, back-to-back then gapped with config churn
    load_123();
    gap_max = 0;
    send_frame(9, 1'b0);
    check_std_lits("std");
    wait_idle();
    set_std();
    gap_max = 3;
    send_frame(9, 1'b1);
    check_std_lits("gapped");

    // single-beat frame held by back-pressure
    wait_idle();
    set_std();
    gap_max = 0;
    m_hold = 1'b1;
    send_beat(8'h01, 1'b1, 1'b1, e);
    check("single_crc", act_crc[0], 32'h07);
    check("single_len", {28'd0, act_len[0]}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_s_ready", {31'd0, act_rdy[0]}, 32'd0);
      check("hold_crc", act_crc[0], 32'h07);
    end
    m_hold = 1'b0;
    m_force = 1'b1;
    send_beat(8'h31, 1'b1, 1'b1, e);
    check("next_sof_edges", 32'(e), 32'd2);
    wait_idle();
    m_force = 1'b0;

    // non-sof beats in IDLE are dropped with an error
    send_beat(8'h55, 1'b0, 1'b0, e);
    check("stray_err", {31'd0, act_err[0]}, 32'd1);
    send_beat(8'h66, 1'b0, 1'b1, e);
    @(posedge clk); #1;
    check("stray_no_result", {31'd0, act_vld[0]}, 32'd0);

    // sof in the middle of a frame restarts it
    set_std();
    send_beat(8'hAA, 1'b1, 1'b0, e);
    send_beat(8'hBB, 1'b0, 1'b0, e);
    send_beat(msg[0], 1'b1, 1'b0, e);
    check("abort_err", {31'd0, act_err[0]}, 32'd1);
    for (int k = 1; k < 9; k++) send_beat(msg[k], 1'b0, k == 8, e);
    check_std_lits("abort");

    // beat counter saturates
    wait_idle();
    for (int k = 0; k < 20; k++) msg[k] = 8'($urandom);
    send_frame(20, 1'b0);
    check("len_sat", {28'd0, act_len[0]}, 32'd15);

    // asynchronous reset mid-frame
    wait_idle();
    set_std();
    send_beat(8'h31, 1'b1, 1'b0, e);
    send_beat(8'h32, 1'b0, 1'b0, e);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, act_vld[0]}, 32'd0);
    check("rst_mid_err", {31'd0, act_err[0]}, 32'd0);
    check("rst_mid_len", {28'd0, act_len[0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // asynchronous reset while a result is pending
    m_hold = 1'b1;
    send_beat(8'h01, 1'b1, 1'b1, e);
    check("pending_valid", {31'd0, act_vld[0]}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_res_valid", {31'd0, act_vld[0]}, 32'd0);
    check("rst_res_crc", act_crc[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hold = 1'b0;
    load_123();
    send_frame(9, 1'b0);
    check_std_lits("post_rst");

    // randomized frames with protocol noise
    for (int f = 0; f < 40; f++) begin
      int r;
      int n;
      gap_max = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0) send_beat(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), e);
      if (r == 1) begin
        send_beat(8'($urandom), 1'b1, 1'b0, e);
        repeat ($urandom_range(0, 3)) send_beat(8'($urandom), 1'b0, 1'b0, e);
      end
      set_rand_cfg();
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) msg[k] = 8'($urandom);
      send_frame(n, 1'b1);
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
